pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program counter datapath of the 6502 core; receiving end of the PC control signal group.
- Holds PCL/PCH, selects each half from itself or from the ADL/ADH address buses, and increments across both halves with carry.
- Places PCL/PCH onto the DB, ADL and ADH internal buses on command.
- Sits between the PC control logic (decoder side) and the internal bus multiplexers.

Parameters:
- RESET_PC, 16'h0000, value loaded into {PCH,PCL} on reset.
- BUS_IDLE, 8'hFF, value shown on an undriven bus output (precharge level).

Ports:
- PHI0  input  1  core clock; one rising edge = one full machine cycle.
- n_RES  input  1  asynchronous active-low reset.
- n_ready  input  1  1 = stall; all PC registers hold.
- PCL_PCL  input  1  PCL select source = PCL.
- ADL_PCL  input  1  PCL select source = ADL bus.
- PCH_PCH  input  1  PCH select source = PCH.
- ADH_PCH  input  1  PCH select source = ADH bus.
- INC_PC  input  1  add 1 to selected PC this cycle.
- PCL_DB  input  1  drive PCL onto DB.
- PCH_DB  input  1  drive PCH onto DB.
- PCL_ADL  input  1  drive PCL onto ADL.
- PCH_ADH  input  1  drive PCH onto ADH.
- ADL  input  8  ADL bus value.
- ADH  input  8  ADH bus value.
- DB_out  output  8  DB drive value.
- DB_drv  output  1  DB driven by PC.
- ADL_out  output  8  ADL drive value.
- ADL_drv  output  1  ADL driven by PC.
- ADH_out  output  8  ADH drive value.
- ADH_drv  output  1  ADH driven by PC.
- PC  output  16  current {PCH,PCL}, for debug.
- conflict  output  1  only present with PC_CONFLICT_EN.

Behaviour:
- Clocking and reset:
  - One clock: PHI0. Reset is n_RES, asynchronous, active-low.
  - On reset, {PCH,PCL} = RESET_PC; all *_drv = 0; all bus outputs = BUS_IDLE; conflict = 0.
  - Reset takes effect immediately, including mid-increment or mid-load; the first edge after release operates normally.
- Select stage (combinational):
  - PCLS = ADL if ADL_PCL, else PCL. ADL_PCL has priority when both ADL_PCL and PCL_PCL are set. When neither is set, PCLS = PCL (hold).
  - PCHS = ADH if ADH_PCH, else PCH, with the same priority and hold rules.
- Increment stage:
  - {carry, PCL_next} = PCLS + INC_PC, 9-bit sum.
  - PCH_next = PCHS + carry, 8-bit wrap.
  - FFFF + 1 = 0000. xxFF + 1 carries into PCH in the same cycle; no delayed carry.
- Register update at PHI0 rising edge:
  - If n_ready = 0: PCL <= PCL_next and PCH <= PCH_next.
  - If n_ready = 1: hold both; INC_PC and the loads are ignored for that cycle.
- Bus outputs, registered one cycle (sampled at the same edge from the pre-update register values):
  - DB_drv <= PCL_DB | PCH_DB.
  - DB_out <= PCL if PCL_DB; else PCH if PCH_DB; else BUS_IDLE. PCL wins when both are set.
  - ADL_drv <= PCL_ADL. ADL_out <= PCL_ADL ? PCL : BUS_IDLE.
  - ADH_drv <= PCH_ADH. ADH_out <= PCH_ADH ? PCH : BUS_IDLE.
  - Bus outputs update even when n_ready = 1; the stall freezes only PC state.
- Latency:
  - Loads and increments are visible on PC one edge after the control is sampled.
  - Drive values show the PC value before that edge's update.
- PC is {PCH,PCL} straight from the registers.

Optional Feature:
- Macro: PC_CONFLICT_EN.
- With the macro:
  - Port conflict exists. It is registered at PHI0 and set for one cycle whenever (ADL_PCL & PCL_PCL) | (ADH_PCH & PCH_PCH) | (PCL_DB & PCH_DB) was sampled.
  - Cleared by reset.
  - Priority behaviour is unchanged.
- Without the macro: the port and its logic are absent. Datapath behaviour is identical.

Test Plan:
- Reset and hold:
  - Stimulus: n_RES low with RESET_PC = 16'h0000, then release; PCL_PCL = PCH_PCH = 1, INC_PC = 1 for 3 edges.
  - Required: PC reads 0000, 0001, 0002, 0003. All *_drv = 0 during reset.
- Page carry and wrap:
  - Stimulus: load ADL = FF, ADH = 12 (ADL_PCL = ADH_PCH = 1, INC_PC = 0), then INC_PC = 1.
  - Required: PC = 12FF, then 1300.
  - Stimulus: load FFFF, then increment.
  - Required: PC = 0000.
- Stall:
  - Stimulus: PC = 2000, n_ready = 1 for 2 edges with INC_PC = 1 and ADL_PCL = 1, ADL = 55.
  - Required: PC stays 2000.
  - Stimulus: n_ready = 0.
  - Required: PC = 2056 (load 55, then increment).
- Bus drive:
  - Stimulus: PC = ABCD; set PCL_ADL = PCH_ADH = 1, then PCH_DB = 1, then PCL_DB = PCH_DB = 1.
  - Required: ADL_out = CD and ADH_out = AB with drv = 1; then DB_out = AB; then DB_out = CD (PCL priority).
  - Required: idle buses read FF with drv = 0.
- Select priority:
  - Stimulus: ADL_PCL = PCL_PCL = 1, ADL = 3C, PC = 1000.
  - Required: PC = 103C.
  - Required with PC_CONFLICT_EN: conflict = 1 for exactly one cycle.
- Reset mid-operation:
  - Stimulus: assert n_RES asynchronously between edges during an increment sequence at PC = 00FF.
  - Required: PC = RESET_PC immediately. The next edge after release increments from RESET_PC.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: 6502 program counter datapath.
// Holds PCL/PCH, selects each half from itself or the ADL/ADH buses, increments
// across both halves with carry, and drives PCL/PCH onto DB/ADL/ADH (registered).
// Optional build macro PC_CONFLICT_EN adds the registered 'conflict' flag output.

module pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  BUS_IDLE = 8'hFF
) (
    input  logic        PHI0,
    input  logic        n_RES,
    input  logic        n_ready,
    input  logic        PCL_PCL,
    input  logic        ADL_PCL,
    input  logic        PCH_PCH,
    input  logic        ADH_PCH,
    input  logic        INC_PC,
    input  logic        PCL_DB,
    input  logic        PCH_DB,
    input  logic        PCL_ADL,
    input  logic        PCH_ADH,
    input  logic [7:0]  ADL,
    input  logic [7:0]  ADH,
    output logic [7:0]  DB_out,
    output logic        DB_drv,
    output logic [7:0]  ADL_out,
    output logic        ADL_drv,
    output logic [7:0]  ADH_out,
    output logic        ADH_drv,
    output logic [15:0] PC
`ifdef PC_CONFLICT_EN
    ,
    output logic        conflict
`endif
);

    logic [7:0] pcl_q, pch_q;
    logic [7:0] pcl_sel, pch_sel;
    logic [7:0] pcl_d, pch_d;
    logic       pcl_carry;

    // PCL_PCL / PCH_PCH only matter as the hold path: bus load wins, and
    // "neither set" also holds, so they never change the selected value.
    logic unused_hold_sel;
    assign unused_hold_sel = PCL_PCL ^ PCH_PCH;

    // Select stage and ripple increment; carry reaches PCH in the same cycle.
    always_comb begin
        pcl_sel              = ADL_PCL ? ADL : pcl_q;
        pch_sel              = ADH_PCH ? ADH : pch_q;
        {pcl_carry, pcl_d}   = {1'b0, pcl_sel} + {8'h00, INC_PC};
        pch_d                = pch_sel + {7'h00, pcl_carry};
    end

    // PC registers; a stall (n_ready = 1) freezes both halves.
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            pcl_q <= RESET_PC[7:0];
            pch_q <= RESET_PC[15:8];
        end else if (!n_ready) begin
            pcl_q <= pcl_d;
            pch_q <= pch_d;
        end
    end

    // Bus drives from the pre-update PC; not affected by the stall.
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            DB_drv  <= 1'b0;
            DB_out  <= BUS_IDLE;
            ADL_drv <= 1'b0;
            ADL_out <= BUS_IDLE;
            ADH_drv <= 1'b0;
            ADH_out <= BUS_IDLE;
        end else begin
            DB_drv  <= PCL_DB | PCH_DB;
            DB_out  <= PCL_DB ? pcl_q : (PCH_DB ? pch_q : BUS_IDLE);
            ADL_drv <= PCL_ADL;
            ADL_out <= PCL_ADL ? pcl_q : BUS_IDLE;
            ADH_drv <= PCH_ADH;
            ADH_out <= PCH_ADH ? pch_q : BUS_IDLE;
        end
    end

`ifdef PC_CONFLICT_EN
    // One-cycle flag for contradictory select or DB drive requests.
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            conflict <= 1'b0;
        end else begin
            conflict <= (ADL_PCL & PCL_PCL) | (ADH_PCH & PCH_PCH) | (PCL_DB & PCH_DB);
        end
    end
`endif

    assign PC = {pch_q, pcl_q};

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed literal checks plus random
// stimulus compared every cycle against a 16-bit arithmetic reference model.

module tb_pc_unit;

    logic        PHI0 = 1'b0;
    logic        n_RES = 1'b1;
    logic        n_ready = 1'b0;
    logic        PCL_PCL = 1'b0, ADL_PCL = 1'b0, PCH_PCH = 1'b0, ADH_PCH = 1'b0;
    logic        INC_PC = 1'b0;
    logic        PCL_DB = 1'b0, PCH_DB = 1'b0, PCL_ADL = 1'b0, PCH_ADH = 1'b0;
    logic [7:0]  ADL = 8'h00, ADH = 8'h00;
    logic [7:0]  DB_out, ADL_out, ADH_out;
    logic        DB_drv, ADL_drv, ADH_drv;
    logic [15:0] PC;
`ifdef PC_CONFLICT_EN
    logic        conflict;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    pc_unit #(.RESET_PC(16'h0000), .BUS_IDLE(8'hFF)) dut (
        .PHI0(PHI0), .n_RES(n_RES), .n_ready(n_ready),
        .PCL_PCL(PCL_PCL), .ADL_PCL(ADL_PCL), .PCH_PCH(PCH_PCH), .ADH_PCH(ADH_PCH),
        .INC_PC(INC_PC), .PCL_DB(PCL_DB), .PCH_DB(PCH_DB),
        .PCL_ADL(PCL_ADL), .PCH_ADH(PCH_ADH), .ADL(ADL), .ADH(ADH),
        .DB_out(DB_out), .DB_drv(DB_drv), .ADL_out(ADL_out), .ADL_drv(ADL_drv),
        .ADH_out(ADH_out), .ADH_drv(ADH_drv), .PC(PC)
`ifdef PC_CONFLICT_EN
        , .conflict(conflict)
`endif
    );

    always #5 PHI0 = ~PHI0;

    // Reference model: PC as one 16-bit number, buses as plain selections.
    logic [15:0] m_pc;
    logic [7:0]  m_db, m_adl, m_adh;
    logic        m_db_drv, m_adl_drv, m_adh_drv, m_conf;

    function automatic logic [15:0] model_next(input logic [15:0] pc);
        logic [7:0] lo, hi;
        lo = ADL_PCL ? ADL : pc[7:0];
        hi = ADH_PCH ? ADH : pc[15:8];
        return {hi, lo} + {15'h0000, INC_PC};
    endfunction

    always @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            m_pc <= 16'h0000;
            m_db <= 8'hFF; m_adl <= 8'hFF; m_adh <= 8'hFF;
            m_db_drv <= 1'b0; m_adl_drv <= 1'b0; m_adh_drv <= 1'b0; m_conf <= 1'b0;
        end else begin
            if (!n_ready) m_pc <= model_next(m_pc);
            m_db_drv  <= PCL_DB | PCH_DB;
            m_db      <= PCL_DB ? m_pc[7:0] : (PCH_DB ? m_pc[15:8] : 8'hFF);
            m_adl_drv <= PCL_ADL;
            m_adl     <= PCL_ADL ? m_pc[7:0] : 8'hFF;
            m_adh_drv <= PCH_ADH;
            m_adh     <= PCH_ADH ? m_pc[15:8] : 8'hFF;
            m_conf    <= (ADL_PCL & PCL_PCL) | (ADH_PCH & PCH_PCH) | (PCL_DB & PCH_DB);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge PHI0) begin
        if (cmp_en) begin
            chk("model PC", PC, m_pc);
            chk("model DB_out", {8'h00, DB_out}, {8'h00, m_db});
            chk("model DB_drv", {15'h0, DB_drv}, {15'h0, m_db_drv});
            chk("model ADL_out", {8'h00, ADL_out}, {8'h00, m_adl});
            chk("model ADL_drv", {15'h0, ADL_drv}, {15'h0, m_adl_drv});
            chk("model ADH_out", {8'h00, ADH_out}, {8'h00, m_adh});
            chk("model ADH_drv", {15'h0, ADH_drv}, {15'h0, m_adh_drv});
`ifdef PC_CONFLICT_EN
            chk("model conflict", {15'h0, conflict}, {15'h0, m_conf});
`endif
        end
    end

    task automatic clear();
        PCL_PCL = 0; ADL_PCL = 0; PCH_PCH = 0; ADH_PCH = 0; INC_PC = 0;
        PCL_DB = 0; PCH_DB = 0; PCL_ADL = 0; PCH_ADH = 0; n_ready = 0;
    endtask

    task automatic tick();
        @(posedge PHI0);
        @(negedge PHI0);
    endtask

    task automatic load(input logic [15:0] v);
        clear();
        ADL_PCL = 1; ADH_PCH = 1; ADL = v[7:0]; ADH = v[15:8];
        tick();
    endtask

    initial begin
        // Reset and hold-increment
        #1 n_RES = 0;
        cmp_en = 1'b1;
        @(negedge PHI0);
        chk("reset PC", PC, 16'h0000);
        chk("reset drv", {13'h0, DB_drv, ADL_drv, ADH_drv}, 16'h0000);
        chk("reset ADL_out", {8'h00, ADL_out}, 16'h00FF);
        #2 n_RES = 1;
        clear();
        PCL_PCL = 1; PCH_PCH = 1; INC_PC = 1;
        tick(); chk("inc 1", PC, 16'h0001);
        tick(); chk("inc 2", PC, 16'h0002);
        tick(); chk("inc 3", PC, 16'h0003);

        // Page carry and full wrap
        load(16'h12FF); chk("load 12FF", PC, 16'h12FF);
        clear(); INC_PC = 1; tick(); chk("page carry", PC, 16'h1300);
        load(16'hFFFF); chk("load FFFF", PC, 16'hFFFF);
        clear(); INC_PC = 1; tick(); chk("wrap", PC, 16'h0000);

        // Stall
        load(16'h2000);
        clear(); n_ready = 1; INC_PC = 1; ADL_PCL = 1; ADL = 8'h55;
        tick(); chk("stall 1", PC, 16'h2000);
        tick(); chk("stall 2", PC, 16'h2000);
        n_ready = 0;
        tick(); chk("stall release", PC, 16'h2056);

        // Bus drive
        load(16'hABCD);
        clear(); PCL_ADL = 1; PCH_ADH = 1;
        tick();
        chk("ADL_out", {8'h00, ADL_out}, 16'h00CD);
        chk("ADH_out", {8'h00, ADH_out}, 16'h00AB);
        chk("adr drv", {14'h0, ADL_drv, ADH_drv}, 16'h0003);
        chk("DB idle", {7'h0, DB_drv, DB_out}, 16'h00FF);
        clear(); PCH_DB = 1;
        tick();
        chk("DB PCH", {7'h0, DB_drv, DB_out}, 16'h01AB);
        chk("ADL idle", {7'h0, ADL_drv, ADL_out}, 16'h00FF);
        clear(); PCL_DB = 1; PCH_DB = 1;
        tick();
        chk("DB PCL prio", {7'h0, DB_drv, DB_out}, 16'h01CD);
        clear();
        tick();
        chk("DB idle again", {7'h0, DB_drv, DB_out}, 16'h00FF);
        chk("ADH idle", {7'h0, ADH_drv, ADH_out}, 16'h00FF);

        // Select priority
        load(16'h1000);
        clear(); ADL_PCL = 1; PCL_PCL = 1; PCH_PCH = 1; ADL = 8'h3C;
        tick(); chk("ADL prio", PC, 16'h103C);
`ifdef PC_CONFLICT_EN
        chk("conflict set", {15'h0, conflict}, 16'h0001);
`endif
        clear();
        tick();
`ifdef PC_CONFLICT_EN
        chk("conflict clear", {15'h0, conflict}, 16'h0000);
`endif
        chk("prio hold", PC, 16'h103C);

        // Reset mid-operation
        clear(); ADL_PCL = 1; ADH_PCH = 1; ADL = 8'hFF; ADH = 8'h00; PCL_ADL = 1;
        tick(); chk("load 00FF", PC, 16'h00FF);
        clear(); INC_PC = 1;
        #2 n_RES = 0;
        #1;
        chk("async reset PC", PC, 16'h0000);
        chk("async reset drv", {13'h0, DB_drv, ADL_drv, ADH_drv}, 16'h0000);
        #1 n_RES = 1;
        tick(); chk("post reset inc", PC, 16'h0001);

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            n_ready = ($urandom_range(0, 3) == 0);
            PCL_PCL = 1'($urandom_range(0, 1));
            ADL_PCL = ($urandom_range(0, 3) == 0);
            PCH_PCH = 1'($urandom_range(0, 1));
            ADH_PCH = ($urandom_range(0, 3) == 0);
            INC_PC  = 1'($urandom_range(0, 1));
            PCL_DB  = 1'($urandom_range(0, 1));
            PCH_DB  = 1'($urandom_range(0, 1));
            PCL_ADL = 1'($urandom_range(0, 1));
            PCH_ADH = 1'($urandom_range(0, 1));
            ADL = 8'($urandom_range(0, 255));
            ADH = 8'($urandom_range(0, 255));
            // Bias toward page-edge values to exercise the carry path
            if ($urandom_range(0, 3) == 0) ADL = 8'hFF;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
